multicycle_controller: RTL and testbench

- Multi-cycle control FSM that sequences the 20-bit-instruction datapath: fetch, decode, execute, memory, writeback.
- Consumes the 6-bit opcode and the ALU zero flag. Drives instruction/data memory request handshakes and all datapath enables and selects.
- Sits between the instruction decoder and the register file, ALU, PC and memories. One instruction in flight; no pipelining.

---
 rtl/multicycle_controller.sv | 215 +++++++++++++++++++++
 tb/tb_multicycle_controller.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller.sv
// Multi-cycle control FSM for the 20-bit-instruction datapath.
// Sequences fetch, decode, execute, memory and writeback with bounded memory waits.
module multicycle_controller #(
   parameter int unsigned MEM_TIMEOUT = 15,
   parameter int unsigned CNT_W       = 8
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [5:0] opcode,
   input  logic       zero,
   input  logic       imem_ready,
   input  logic       dmem_ready,
   output logic       imem_req,
   output logic       dmem_req,
   output logic       dmem_we,
   output logic       ir_write,
   output logic       pc_write,
   output logic [1:0] pc_src,
   output logic       alu_src_imm,
   output logic       reg_write,
   output logic [1:0] wb_sel,
   output logic       halted,
   output logic [1:0] fault,
   output logic [2:0] state
);

   typedef enum logic [2:0] {
      StFetch  = 3'd0,
      StDecode = 3'd1,
      StExec   = 3'd2,
      StMem    = 3'd3,
      StWb     = 3'd4,
      StHalt   = 3'd5
   } state_e;

   typedef enum logic [3:0] {
      ClsAlu,
      ClsAluImm,
      ClsBranch,
      ClsLoad,
      ClsStore,
      ClsJump,
      ClsMov,
      ClsHalt,
      ClsIllegal
   } op_class_e;

   localparam logic [1:0]       PcNext    = 2'd0;
   localparam logic [1:0]       PcBranch  = 2'd1;
   localparam logic [1:0]       PcJump    = 2'd2;
   localparam logic [1:0]       WbAlu     = 2'd0;
   localparam logic [1:0]       WbMem     = 2'd1;
   localparam logic [1:0]       WbImm     = 2'd2;
   localparam logic [1:0]       FltHalt   = 2'd0;
   localparam logic [1:0]       FltIll    = 2'd1;
   localparam logic [1:0]       FltTmo    = 2'd2;
   localparam logic [CNT_W-1:0] TimeoutCnt = CNT_W'(MEM_TIMEOUT);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [1:0]       fault_q, fault_d;
   op_class_e        op_class;
   logic             wait_expired;

   always_comb begin
      op_class = ClsIllegal;
      casez (opcode)
         6'b00????: op_class = ClsAlu;
         6'b0100??: op_class = ClsAluImm;
         6'b0101??: op_class = ClsBranch;
         6'b0110??: op_class = ClsLoad;
         6'b0111??: op_class = ClsStore;
         6'b100???: op_class = ClsJump;
         6'b101???: op_class = ClsMov;
         6'b111111: op_class = ClsHalt;
         default:   op_class = ClsIllegal;
      endcase
   end

   // The access may still complete in the cycle the count sits at the limit.
   assign wait_expired = (cnt_q == TimeoutCnt);

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      fault_d     = fault_q;
      imem_req    = 1'b0;
      dmem_req    = 1'b0;
      dmem_we     = 1'b0;
      ir_write    = 1'b0;
      pc_write    = 1'b0;
      pc_src      = PcNext;
      alu_src_imm = 1'b0;
      reg_write   = 1'b0;
      wb_sel      = WbAlu;
      halted      = 1'b0;
      fault       = 2'd0;

      case (state_q)
         StFetch: begin
            imem_req = 1'b1;
            if (imem_ready) begin
               ir_write = 1'b1;
               state_d  = StDecode;
            end else if (wait_expired) begin
               state_d = StHalt;
               fault_d = FltTmo;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end

         StDecode: state_d = StExec;

         StExec: begin
            case (op_class)
               ClsAlu:    state_d = StWb;
               ClsAluImm: begin
                  alu_src_imm = 1'b1;
                  state_d     = StWb;
               end
               ClsLoad, ClsStore: begin
                  alu_src_imm = 1'b1;
                  state_d     = StMem;
               end
               ClsBranch: begin
                  pc_write = 1'b1;
                  pc_src   = zero ? PcBranch : PcNext;
                  state_d  = StFetch;
               end
               ClsJump: begin
                  pc_write = 1'b1;
                  pc_src   = PcJump;
                  state_d  = StFetch;
               end
               ClsMov:    state_d = StWb;
               ClsHalt: begin
                  state_d = StHalt;
                  fault_d = FltHalt;
               end
               default: begin
                  state_d = StHalt;
                  fault_d = FltIll;
               end
            endcase
         end

         StMem: begin
            dmem_req = 1'b1;
            dmem_we  = (op_class == ClsStore);
            if (dmem_ready) begin
               if (op_class == ClsStore) begin
                  pc_write = 1'b1;
                  pc_src   = PcNext;
                  state_d  = StFetch;
               end else begin
                  state_d = StWb;
               end
            end else if (wait_expired) begin
               state_d = StHalt;
               fault_d = FltTmo;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end

         StWb: begin
            reg_write   = 1'b1;
            pc_write    = 1'b1;
            pc_src      = PcNext;
            alu_src_imm = (op_class == ClsAluImm) || (op_class == ClsLoad);
            if (op_class == ClsLoad) begin
               wb_sel = WbMem;
            end else if (op_class == ClsMov) begin
               wb_sel = WbImm;
            end else begin
               wb_sel = WbAlu;
            end
            state_d = StFetch;
         end

         StHalt: begin
            halted = 1'b1;
            fault  = fault_q;
         end

         default: state_d = StFetch;
      endcase

      // Each memory-waiting state starts its count afresh.
      if ((state_d != state_q) && ((state_d == StFetch) || (state_d == StMem))) begin
         cnt_d = '0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= StFetch;
         cnt_q   <= '0;
         fault_q <= 2'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         fault_q <= fault_d;
      end
   end

   assign state = state_q;

   a_we_needs_req : assert property (@(posedge clk) disable iff (!reset_n) dmem_we |-> dmem_req);
   a_halt_sticky  : assert property (@(posedge clk) disable iff (!reset_n)
                                     state_q == StHalt |=> state_q == StHalt);
   a_cnt_bounded  : assert property (@(posedge clk) disable iff (!reset_n) cnt_q <= TimeoutCnt);

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: builds the expected per-cycle trace of each
// instruction from its class and memory wait counts, then plays and compares it.
module tb_multicycle_controller;

   localparam int T = 15;

   localparam int C_ALU = 0, C_ALUI = 1, C_BR = 2, C_LD = 3, C_ST = 4, C_JMP = 5,
                  C_MOV = 6, C_HALT = 7, C_ILL = 8;

   typedef struct packed {
      logic [2:0] st;
      logic       imem_req;
      logic       dmem_req;
      logic       dmem_we;
      logic       ir_write;
      logic       pc_write;
      logic [1:0] pc_src;
      logic       alu_src_imm;
      logic       reg_write;
      logic [1:0] wb_sel;
      logic       halted;
      logic [1:0] fault;
   } outs_t;

   typedef struct {
      outs_t exp;
      logic  ir;
      logic  dr;
      logic  z;
   } step_t;

   logic       clk = 1'b0;
   logic       reset_n;
   logic [5:0] opcode;
   logic       zero, imem_ready, dmem_ready;
   logic       imem_req, dmem_req, dmem_we, ir_write, pc_write, alu_src_imm, reg_write, halted;
   logic [1:0] pc_src, wb_sel, fault;
   logic [2:0] state;
   outs_t      act;

   int    n_checks = 0;
   int    n_errors = 0;
   step_t trace[$];
   int    instr_no = 0;

   always #5 clk = ~clk;

   multicycle_controller #(.MEM_TIMEOUT(T), .CNT_W(8)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .opcode     (opcode),
      .zero       (zero),
      .imem_ready (imem_ready),
      .dmem_ready (dmem_ready),
      .imem_req   (imem_req),
      .dmem_req   (dmem_req),
      .dmem_we    (dmem_we),
      .ir_write   (ir_write),
      .pc_write   (pc_write),
      .pc_src     (pc_src),
      .alu_src_imm(alu_src_imm),
      .reg_write  (reg_write),
      .wb_sel     (wb_sel),
      .halted     (halted),
      .fault      (fault),
      .state      (state)
   );

   assign act = {state, imem_req, dmem_req, dmem_we, ir_write, pc_write, pc_src,
                 alu_src_imm, reg_write, wb_sel, halted, fault};

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic int cls_of(input logic [5:0] op);
      if (op[5:4] == 2'b00) return C_ALU;
      if (op[5:2] == 4'b0100) return C_ALUI;
      if (op[5:2] == 4'b0101) return C_BR;
      if (op[5:2] == 4'b0110) return C_LD;
      if (op[5:2] == 4'b0111) return C_ST;
      if (op[5:3] == 3'b100) return C_JMP;
      if (op[5:3] == 3'b101) return C_MOV;
      if (op == 6'h3f) return C_HALT;
      return C_ILL;
   endfunction

   task automatic push(input outs_t e, input logic ir, input logic dr, input logic z);
      step_t s;
      s.exp = e;
      s.ir  = ir;
      s.dr  = dr;
      s.z   = z;
      trace.push_back(s);
   endtask

   task automatic push_halt(input logic [1:0] f);
      outs_t e;
      for (int i = 0; i < 3; i++) begin
         e        = '0;
         e.st     = 3'd5;
         e.halted = 1'b1;
         e.fault  = f;
         push(e, 1'($urandom), 1'($urandom), 1'($urandom));
      end
   endtask

   // Expected cycle-by-cycle behaviour of one instruction. iw/dw are the number of
   // cycles the memory keeps ready low; more than T means the access times out.
   task automatic build(input logic [5:0] op, input logic z, input int iw, input int dw,
                        output bit stops);
      outs_t e;
      int    c;
      c     = cls_of(op);
      stops = 1'b0;
      trace.delete();
      for (int k = 0; k <= T && k <= iw; k++) begin
         e          = '0;
         e.imem_req = 1'b1;
         e.ir_write = (k == iw);
         push(e, (k == iw), 1'($urandom), 1'($urandom));
      end
      if (iw > T) begin
         push_halt(2'd2);
         stops = 1'b1;
         return;
      end
      e    = '0;
      e.st = 3'd1;
      push(e, 1'($urandom), 1'($urandom), 1'($urandom));
      e    = '0;
      e.st = 3'd2;
      if (c == C_ALUI || c == C_LD || c == C_ST) e.alu_src_imm = 1'b1;
      if (c == C_BR) begin
         e.pc_write = 1'b1;
         e.pc_src   = z ? 2'd1 : 2'd0;
      end
      if (c == C_JMP) begin
         e.pc_write = 1'b1;
         e.pc_src   = 2'd2;
      end
      push(e, 1'($urandom), 1'($urandom), z);
      if (c == C_BR || c == C_JMP) return;
      if (c == C_HALT || c == C_ILL) begin
         push_halt((c == C_ILL) ? 2'd1 : 2'd0);
         stops = 1'b1;
         return;
      end
      if (c == C_LD || c == C_ST) begin
         for (int k = 0; k <= T && k <= dw; k++) begin
            e          = '0;
            e.st       = 3'd3;
            e.dmem_req = 1'b1;
            e.dmem_we  = (c == C_ST);
            e.pc_write = (c == C_ST) && (k == dw);
            push(e, 1'($urandom), (k == dw), 1'($urandom));
         end
         if (dw > T) begin
            push_halt(2'd2);
            stops = 1'b1;
            return;
         end
         if (c == C_ST) return;
      end
      e             = '0;
      e.st          = 3'd4;
      e.reg_write   = 1'b1;
      e.pc_write    = 1'b1;
      e.alu_src_imm = (c == C_ALUI) || (c == C_LD);
      e.wb_sel      = (c == C_LD) ? 2'd1 : ((c == C_MOV) ? 2'd2 : 2'd0);
      push(e, 1'($urandom), 1'($urandom), 1'($urandom));
   endtask

   // Starts and ends on a falling edge; plays at most lim steps of the trace.
   task automatic play(input logic [5:0] op, input int lim);
      opcode = op;
      for (int i = 0; i < trace.size() && i < lim; i++) begin
         imem_ready = trace[i].ir;
         dmem_ready = trace[i].dr;
         zero       = trace[i].z;
         #2;
         check($sformatf("instr%0d op%02h cyc%0d", instr_no, op, i), 32'(act),
               32'(trace[i].exp));
         @(negedge clk);
      end
      instr_no++;
   endtask

   task automatic reset_cycle();
      reset_n = 1'b0;
      #1;
      check("reset_state", 32'(state), 32'd0);
      check("reset_halted_fault", {halted, fault}, 3'b000);
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   task automatic run(input logic [5:0] op, input logic z, input int iw, input int dw);
      bit stops;
      build(op, z, iw, dw, stops);
      play(op, 1 << 30);
      if (stops) reset_cycle();
   endtask

   initial begin
      bit          stops;
      logic [5:0]  op;
      int          r, iw, dw;
      reset_n    = 1'b0;
      opcode     = '0;
      zero       = 1'b0;
      imem_ready = 1'b0;
      dmem_ready = 1'b0;
      #2;
      check("por_state", 32'(state), 32'd0);
      check("por_fault", 32'(fault), 32'd0);
      check("por_imem_req", 32'(imem_req), 32'd1);
      @(negedge clk);
      reset_n = 1'b1;

      run(6'b000000, 1'b0, 0, 0);    // R-type
      run(6'b010101, 1'b1, 0, 0);    // branch taken
      run(6'b010101, 1'b0, 0, 0);    // branch not taken
      run(6'b011000, 1'b0, 0, 3);    // load with 3 wait states
      run(6'b011100, 1'b0, 0, 0);    // store
      run(6'b101010, 1'b0, 0, 0);    // mov
      run(6'b100000, 1'b0, 0, 0);    // jump
      run(6'b010011, 1'b0, 2, 0);    // ALU immediate with fetch waits
      run(6'b000001, 1'b0, T, 0);    // ready exactly at the limit
      run(6'b011101, 1'b0, 1, T);    // store completes at the limit
      run(6'b000000, 1'b0, T + 1, 0); // fetch timeout
      run(6'b011000, 1'b0, 0, T + 1); // load timeout
      run(6'b110000, 1'b0, 0, 0);    // illegal
      run(6'b111111, 1'b0, 0, 0);    // halt

      // Asynchronous reset in the middle of a data access.
      build(6'b011000, 1'b0, 0, 10, stops);
      play(6'b011000, 6);
      dmem_ready = 1'b0;
      #2;
      check("mid_mem_req_before", 32'(dmem_req), 32'd1);
      reset_n = 1'b0;
      #1;
      check("async_rst_dmem_req", 32'(dmem_req), 32'd0);
      check("async_rst_state", 32'(state), 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      run(6'b000010, 1'b0, T, 0);    // counter must restart from 0

      for (int n = 0; n < 250; n++) begin
         r = $urandom_range(0, 99);
         if (r < 3) begin
            op = 6'h3f;
         end else if (r < 6) begin
            op = {3'b110, 3'($urandom)};
         end else begin
            do op = 6'($urandom); while (cls_of(op) == C_HALT || cls_of(op) == C_ILL);
         end
         iw = ($urandom_range(0, 99) < 60) ? 0 : $urandom_range(0, T + 1);
         dw = ($urandom_range(0, 99) < 60) ? 0 : $urandom_range(0, T + 1);
         run(op, 1'($urandom), iw, dw);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

endmodule
